// File: rtl/rtc_count_ctrl.sv
// Real-time counter controller: a prescaled up-counter with load handshake and an
// optional match interrupt.
// Latency: Count, Tick and RawInt are registered (1 cycle). LoadAck and Int are
// combinational from registered state.
// Backpressure: none. A load request is a level that is held until LoadAck.
//   A new load is accepted only after LoadReq has been seen low again.
//
// Configuration macro: RTC_MATCH_EN
//   defined   - match/interrupt logic is present.
//   undefined - RawInt and Int are tied low, and MatchData/IntMask/IntClr are ignored.
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   RtcEn, Divisor      run enable, tick period minus one (PCLK cycles)
//   LoadReq/LoadData    counter load request (level) and value; LoadAck one-cycle ack
//   MatchData, IntMask  match compare value, interrupt output enable
//   IntClr              one-cycle clear of the match status
//   Count, Tick         counter value, pulse in the cycle Count shows an increment
//   RawInt, Int         match status, masked interrupt
//   State               FSM state: STOP=00, RUN=01, LOAD=10
module rtc_count_ctrl #(
   parameter int CNT_W = 32,
   parameter int DIV_W = 16
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             RtcEn,
   input  logic [DIV_W-1:0] Divisor,
   input  logic             LoadReq,
   input  logic [CNT_W-1:0] LoadData,
   output logic             LoadAck,
   input  logic [CNT_W-1:0] MatchData,
   input  logic             IntMask,
   input  logic             IntClr,
   output logic [CNT_W-1:0] Count,
   output logic             Tick,
   output logic             RawInt,
   output logic             Int,
   output logic [1:0]       State
);

   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_RUN  = 2'b01,
      ST_LOAD = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             tick_q, tick_d;
   logic             armed_q, armed_d;
   logic             raw_q, raw_d;
   logic             cnt_upd;
   logic             load_go;

   // A request loads only once per assertion.
   // It must be seen low before it can arm again.
   assign load_go = LoadReq & armed_q;

   // FSM: state register
   always_ff @(posedge PCLK) begin
      if (PRESET) state_q <= ST_STOP;
      else        state_q <= state_d;
   end

   // FSM: next-state logic
   always_comb begin
      state_d = ST_STOP;
      unique case (state_q)
         ST_STOP: begin
            if (load_go)    state_d = ST_LOAD;
            else if (RtcEn) state_d = ST_RUN;
            else            state_d = ST_STOP;
         end
         ST_RUN: begin
            if (load_go)     state_d = ST_LOAD;
            else if (!RtcEn) state_d = ST_STOP;
            else             state_d = ST_RUN;
         end
         ST_LOAD: state_d = RtcEn ? ST_RUN : ST_STOP;
         default: state_d = ST_STOP;   // unreachable encoding recovers to STOP
      endcase
   end

   // FSM: outputs. A reset asserted during LOAD suppresses the acknowledge.
   always_comb begin
      LoadAck = (state_q == ST_LOAD) && !PRESET;
      State   = state_q;
   end

   // Prescaler, counter and load-arming datapath
   always_comb begin
      presc_d = '0;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      cnt_upd = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            // A pending load or a stop takes priority over counting.
            // In both cases the prescaler is left cleared.
            if (!load_go && RtcEn) begin
               // Use >= rather than == so that a Divisor lowered below the
               // current prescaler value ticks on the next cycle.
               if (presc_q >= Divisor) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  tick_d  = 1'b1;
                  cnt_upd = 1'b1;
               end else begin
                  presc_d = presc_q + DIV_W'(1);
               end
            end
         end
         ST_LOAD: begin
            cnt_d   = LoadData;
            cnt_upd = 1'b1;
         end
         default: ;
      endcase

      armed_d = armed_q;
      if (state_d == ST_LOAD) armed_d = 1'b0;
      else if (!LoadReq)      armed_d = 1'b1;
   end

`ifdef RTC_MATCH_EN
   // Match status sets only on an actual counter update.
   // A set outranks a clear issued in the same cycle.
   always_comb begin
      raw_d = raw_q;
      if (cnt_upd && (cnt_d == MatchData)) raw_d = 1'b1;
      else if (IntClr)                     raw_d = 1'b0;
   end
   assign Int = raw_q & IntMask;
`else
   logic unused_match;
   assign unused_match = ^{MatchData, IntMask, IntClr, cnt_upd};
   assign raw_d        = 1'b0;
   assign Int          = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt_q   <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
         armed_q <= 1'b1;
         raw_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         armed_q <= armed_d;
         raw_q   <= raw_d;
      end
   end

   assign Count  = cnt_q;
   assign Tick   = tick_q;
   assign RawInt = raw_q;

endmodule
